// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate vector sequencer.
package gate_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t DRIVE  = 2'd1;
  localparam state_t SAMPLE = 2'd2;
  localparam state_t DONE   = 2'd3;

  localparam int unsigned NUM_VEC = 4;

  // Truth tables, bit index = {A,B}
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VEC-1:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_vector_sequencer_hold_counter.sv
// 8-bit loadable down-counter timing how long each vector is held.
module seq_hold_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt;

  // load wins over decrement; counter sits at 0 until reloaded
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt - 8'd1;
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives {A,B} = 00..11 into a 2-input gate, samples Y after a hold
// window and compares it against a truth table.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned        HOLD_CYCLES = 4,
  parameter logic [NUM_VEC-1:0] EXPECTED    = 4'b1000,
  parameter bit                 LOOP_EN     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               Y,
  output logic               A,
  output logic               B,
  output logic [1:0]         vec_idx,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] fail_mask
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t state;
  logic   cnt_zero;
  logic   last_vec;
  logic   sweep_go;
  logic   cnt_load;

  assign last_vec = (vec_idx == 2'd3);
  // a fresh sweep starts from IDLE, or back-to-back from DONE in loop mode
  assign sweep_go = start && ((state == IDLE) || (LOOP_EN && state == DONE));
  assign cnt_load = sweep_go || (state == SAMPLE && !last_vec);

  seq_hold_counter u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (state == DRIVE && !cnt_zero),
    .load_val (HOLD_LOAD),
    .zero     (cnt_zero)
  );

  // sweep FSM, vector index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec_idx   <= '0;
      fail_mask <= '0;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state     <= DRIVE;
          vec_idx   <= '0;
          fail_mask <= '0;
          pass      <= 1'b0;
        end
        DRIVE: if (cnt_zero) state <= SAMPLE;
        SAMPLE: begin
          fail_mask[vec_idx] <= (Y != EXPECTED[vec_idx]);
          if (last_vec) state <= DONE;
          else begin
            vec_idx <= vec_idx + 2'd1;
            state   <= DRIVE;
          end
        end
        DONE: begin
          // verdict of the sweep just finished stays visible while looping
          pass <= ~|fail_mask;
          if (sweep_go) begin
            state     <= DRIVE;
            vec_idx   <= '0;
            fail_mask <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // gate inputs follow the index only while a sweep is active
  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE);
    done = (state == DONE);
    A    = busy & vec_idx[1];
    B    = busy & vec_idx[0];
  end

endmodule
